// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter: round-robin sequencer that shares an SR flag bank among requesters.
// Optional macro SR_FLAG_ARB_READBACK_EN adds a q_in readback check in CHECK.
module sr_flag_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_FLAGS = 8,
  parameter int IDX_W     = $clog2(NUM_FLAGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       req_set,
  input  logic [NUM_REQ*IDX_W-1:0] req_idx,
  input  logic [NUM_FLAGS-1:0]     q_in,
  output logic [NUM_FLAGS-1:0]     s_out,
  output logic [NUM_FLAGS-1:0]     r_out,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     err,
  output logic                     busy
);
  localparam int WIN_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  state_t               r_state;
  logic [WIN_W-1:0]     r_last_win;
  logic [WIN_W-1:0]     r_win;
  logic                 r_set;
  logic                 r_oor;
  logic [IDX_W-1:0]     r_idx;
  logic [NUM_FLAGS-1:0] r_s;
  logic [NUM_FLAGS-1:0] r_r;
  logic [NUM_REQ-1:0]   r_ack;
  logic                 r_err;
  logic                 r_busy;

  logic [IDX_W-1:0]     w_idx [NUM_REQ];
  logic                 w_found;
  logic [WIN_W-1:0]     w_win;
  logic [IDX_W-1:0]     w_sel_idx;
  logic                 w_sel_set;
  logic                 w_sel_oor;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_idx[gi] = req_idx[gi*IDX_W +: IDX_W];
    end
  endgenerate

  // Search starts one past the last winner so a repeat requester queues behind all others.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last_win;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_found && req[(int'(r_last_win) + k) % NUM_REQ]) begin
        w_found = 1'b1;
        w_win   = WIN_W'((int'(r_last_win) + k) % NUM_REQ);
      end
    end
  end

  assign w_sel_idx = w_idx[w_win];
  assign w_sel_set = req_set[w_win];
  assign w_sel_oor = int'(w_sel_idx) >= NUM_FLAGS;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_last_win <= WIN_W'(NUM_REQ - 1);
      r_win      <= '0;
      r_set      <= 1'b0;
      r_oor      <= 1'b0;
      r_idx      <= '0;
      r_s        <= '0;
      r_r        <= '0;
      r_ack      <= '0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_s   <= '0;
      r_r   <= '0;
      r_ack <= '0;
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_win  <= w_win;
            r_set  <= w_sel_set;
            r_idx  <= w_sel_idx;
            r_oor  <= w_sel_oor;
            if (!w_sel_oor) begin
              if (w_sel_set) r_s[w_sel_idx] <= 1'b1;
              else           r_r[w_sel_idx] <= 1'b1;
            end
            r_busy  <= 1'b1;
            r_state <= DRIVE;
          end
        end
        DRIVE: begin
          r_ack[r_win] <= 1'b1;
          r_err        <= r_oor;
          r_last_win   <= r_win;
          r_state      <= CHECK;
        end
        CHECK: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef SR_FLAG_ARB_READBACK_EN
  logic w_rb_fail;
  // The bank captures on the edge ending DRIVE, so q_in is compared live during CHECK.
  assign w_rb_fail = (r_state == CHECK) && !r_oor && (q_in[r_idx] != r_set);
  assign err       = r_err | w_rb_fail;
`else
  logic w_unused_rb;
  assign w_unused_rb = ^{q_in, r_idx, r_set};
  assign err         = r_err;
`endif

  assign s_out = r_s;
  assign r_out = r_r;
  assign ack   = r_ack;
  assign busy  = r_busy;
endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed bench for sr_flag_arbiter: an 8-flag instance plus a 6-flag instance for
// out-of-range indices, each fed by a behavioural SR bank model.
module tb_sr_flag_arbiter;
  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  req_set;
  logic [11:0] req_idx;

  logic [7:0]  bank8;
  logic [7:0]  fmask;
  logic [7:0]  q_in;
  logic [7:0]  s_out, r_out;
  logic [3:0]  ack;
  logic        err, busy;

  logic [5:0]  bank6;
  logic [5:0]  q6;
  logic [5:0]  s6, r6;
  logic [3:0]  ack6;
  logic        err6, busy6;

  int n_checks = 0;
  int n_errors = 0;
  int w;

`ifdef SR_FLAG_ARB_READBACK_EN
  localparam logic RB_EN = 1'b1;
`else
  localparam logic RB_EN = 1'b0;
`endif

  sr_flag_arbiter #(.NUM_REQ(4), .NUM_FLAGS(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_set(req_set), .req_idx(req_idx),
    .q_in(q_in), .s_out(s_out), .r_out(r_out), .ack(ack), .err(err), .busy(busy)
  );

  sr_flag_arbiter #(.NUM_REQ(4), .NUM_FLAGS(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_set(req_set), .req_idx(req_idx),
    .q_in(q6), .s_out(s6), .r_out(r6), .ack(ack6), .err(err6), .busy(busy6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial bank8 = '0;
  initial bank6 = '0;
  always @(posedge clk) begin
    bank8 <= (bank8 | s_out) & ~r_out;
    bank6 <= (bank6 | s6) & ~r6;
  end
  assign q_in = bank8 & ~fmask;
  assign q6   = bank6;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic txn(input string tag);
    $display("txn %-10s ack=%b err=%b s=%h r=%h q=%h", tag, ack, err, s_out, r_out, q_in);
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = '0;
    req_set = '0;
    req_idx = '0;
    fmask   = '0;
    tick();
    tick();
    check("rst_s_out", s_out, 0);
    check("rst_r_out", r_out, 0);
    check("rst_ack",   ack,   0);
    check("rst_err",   err,   0);
    check("rst_busy",  busy,  0);

    // single request: requester 0 sets flag 3
    rst_n        = 1'b1;
    req          = 4'b0001;
    req_set      = 4'b0001;
    req_idx[2:0] = 3'd3;
    tick();
    check("single_s",     s_out, 8'h08);
    check("single_r",     r_out, 8'h00);
    check("single_ack1",  ack,   0);
    check("single_busy1", busy,  1);
    tick();
    txn("single");
    check("single_s_off", s_out, 8'h00);
    check("single_ack",   ack,   4'b0001);
    check("single_err",   err,   0);
    check("single_q3",    q_in[3], 1);
    check("single_busy2", busy,  1);
    req = '0;
    tick();
    check("single_ack3",  ack,   0);
    check("single_busy3", busy,  0);

    // all requesters at once after a fresh reset: order 0,1,2,3,0
    rst_n = 1'b0;
    tick();
    rst_n   = 1'b1;
    req_set = 4'b0101;
    req_idx = {3'd3, 3'd2, 3'd1, 3'd0};
    req     = 4'b1111;
    for (int i = 1; i <= 15; i++) begin
      tick();
      w = (i / 3) % 4;
      check("rr_ack", ack, (i % 3 == 2) ? (32'd1 << w) : 32'd0);
      check("rr_overlap", s_out & r_out, 0);
      if (i % 3 == 1) begin
        check("rr_s", s_out, (w % 2 == 0) ? (32'd1 << w) : 32'd0);
        check("rr_r", r_out, (w % 2 == 1) ? (32'd1 << w) : 32'd0);
      end
      if (i % 3 == 2) txn("rr");
    end
    req = '0;
    tick();
    check("rr_idle_busy", busy, 0);

    // set then clear flag 5
    req          = 4'b0100;
    req_set      = 4'b0100;
    req_idx[8:6] = 3'd5;
    tick();
    check("sc_set_s", s_out, 8'h20);
    tick();
    txn("set5");
    check("sc_set_ack", ack, 4'b0100);
    check("sc_set_q5",  q_in[5], 1);
    req = '0;
    tick();
    req          = 4'b0010;
    req_set      = 4'b0000;
    req_idx[5:3] = 3'd5;
    tick();
    check("sc_clr_r", r_out, 8'h20);
    check("sc_clr_s", s_out, 8'h00);
    tick();
    txn("clr5");
    check("sc_clr_ack", ack, 4'b0010);
    check("sc_clr_err", err, 0);
    check("sc_clr_q5",  q_in[5], 0);
    check("sc_clr_r_off", r_out, 8'h00);
    req = '0;
    tick();

    // index 7: out of range for 6 flags, top flag for 8 flags
    req          = 4'b0001;
    req_set      = 4'b0001;
    req_idx[2:0] = 3'd7;
    tick();
    check("oor_s6",  s6,    6'h00);
    check("oor_r6",  r6,    6'h00);
    check("oor_s8",  s_out, 8'h80);
    tick();
    txn("oor");
    check("oor_ack6", ack6, 4'b0001);
    check("oor_err6", err6, 1);
    check("oor_err8", err,  0);
    check("oor_s6_chk", s6, 6'h00);
    req = '0;
    tick();

    // readback fault: q_in[2] held low during a set of flag 2
    fmask        = 8'h04;
    req          = 4'b0001;
    req_set      = 4'b0001;
    req_idx[2:0] = 3'd2;
    tick();
    check("rb_s", s_out, 8'h04);
    tick();
    txn("rbfault");
    check("rb_ack", ack, 4'b0001);
    check("rb_err", err, RB_EN);
    req = '0;
    tick();
    fmask = '0;

    // reset during DRIVE aborts; requester 0 wins first afterwards
    req     = 4'b1110;
    req_set = 4'b1111;
    req_idx = {3'd3, 3'd2, 3'd1, 3'd0};
    tick();
    check("mid_drive_s", s_out, 8'h02);
    rst_n = 1'b0;
    tick();
    check("mid_rst_s",    s_out, 0);
    check("mid_rst_r",    r_out, 0);
    check("mid_rst_ack",  ack,   0);
    check("mid_rst_err",  err,   0);
    check("mid_rst_busy", busy,  0);
    tick();
    check("mid_rst_ack2", ack, 0);
    rst_n = 1'b1;
    req   = 4'b1111;
    tick();
    check("post_rst_s", s_out, 8'h01);
    tick();
    txn("post_rst");
    check("post_rst_ack", ack, 4'b0001);
    req = '0;
    tick();
    check("post_rst_busy", busy | busy6, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
